// File: rtl/click_decoder_pkg.sv
// click_decoder_pkg: shared event/FSM types and click classification for click_decoder.
// Holds the evt_t encoding (NONE=0, REVEAL, FLAG, CHORD) and the decoder FSM states.
// Optional macro CLICK_DECODER_CHORD_EN: simultaneous left+right edges classify as CHORD.
package click_decoder_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, REVEAL = 2'd1, FLAG = 2'd2, CHORD = 2'd3} evt_t;
  typedef enum logic [2:0] {IDLE, CAPTURE, DIVIDE, CHECK, HOLD} state_t;
  // Only called when at least one button rose, so "not left" implies right.
  function automatic evt_t click_kind(input logic l, input logic r);
`ifdef CLICK_DECODER_CHORD_EN
    return (l && r) ? CHORD : l ? REVEAL : FLAG;
`else
    return (l || !r) ? REVEAL : FLAG;
`endif
  endfunction
endpackage

// File: rtl/click_decoder_divider.sv
// seq_divider: restoring bit-serial unsigned divider, one quotient bit per cycle.
// Ports: clk, rst (async active-low), start (loads operands and performs the first step),
//        dividend, divisor (W bits), quotient (W bits), done (one-cycle pulse once all
//        W quotient bits are in, W cycles after start is sampled).
module seq_divider #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] quo, rem, dvs, src_quo, src_rem, src_dvs;
  logic [CW-1:0] cnt;
  logic run, ge;
  logic [W:0] shifted;
  // On start the step works straight from the operands so no cycle is spent loading.
  always_comb begin
    src_quo = start ? dividend : quo;
    src_rem = start ? '0 : rem;
    src_dvs = start ? divisor : dvs;
    shifted = {src_rem, src_quo[W-1]};
    ge = shifted >= {1'b0, src_dvs};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || run) begin
        quo <= {src_quo[W-2:0], ge};
        rem <= ge ? W'(shifted - {1'b0, src_dvs}) : shifted[W-1:0];
        dvs <= src_dvs;
        cnt <= start ? CW'(1) : cnt + CW'(1);
        run <= start ? (W > 1) : (cnt != CW'(W - 1));
        done <= start ? (W == 1) : (cnt == CW'(W - 1));
      end
    end
  end
  assign quotient = quo;
endmodule

// File: rtl/click_decoder.sv
// click_decoder: turns mouse button edges over a square board into 1-based cell events.
// Ports: clk, rst (async active-low); mouse_xpos/ypos, left/right (level buttons);
//        board_xpos/ypos, board_size, button_size, button_num (board geometry);
//        evt_valid/evt_ready handshake with evt_type, cell_x, cell_y; busy; evt_drop pulse.
// Optional macro CLICK_DECODER_CHORD_EN enables CHORD events for simultaneous edges.
module click_decoder
  import click_decoder_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] mouse_xpos,
  input  logic [COORD_W-1:0] mouse_ypos,
  input  logic               left,
  input  logic               right,
  input  logic [COORD_W-1:0] board_xpos,
  input  logic [COORD_W-1:0] board_ypos,
  input  logic [COORD_W-1:0] board_size,
  input  logic [COORD_W-1:0] button_size,
  input  logic [IDX_W-1:0]   button_num,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_type,
  output logic [IDX_W-1:0]   cell_x,
  output logic [IDX_W-1:0]   cell_y,
  output logic               busy,
  output logic               evt_drop
);
  state_t state;
  evt_t kind;
  logic [1:0] hist_l, hist_r, arm;
  logic [COORD_W-1:0] mx, my, bx, by, bsz, csz, qx, qy;
  logic [IDX_W-1:0] bnum;
  logic [COORD_W:0] off_x, off_y;
  logic rise_l, rise_r, any_rise, done_x, done_y, in_range;
  // arm keeps a button held across reset release from looking like a fresh edge.
  assign rise_l = arm[1] & hist_l[0] & ~hist_l[1];
  assign rise_r = arm[1] & hist_r[0] & ~hist_r[1];
  assign any_rise = rise_l | rise_r;
  // The extra top bit is the sign: set means the pointer is left of / above the board.
  assign off_x = {1'b0, mx} - {1'b0, bx};
  assign off_y = {1'b0, my} - {1'b0, by};
  assign in_range = !off_x[COORD_W] && !off_y[COORD_W] &&
                    off_x[COORD_W-1:0] < bsz && off_y[COORD_W-1:0] < bsz &&
                    csz != '0 && bnum != '0 &&
                    qx < COORD_W'(bnum) && qy < COORD_W'(bnum);
  seq_divider #(.W(COORD_W)) u_div_x (
    .clk(clk), .rst(rst), .start(state == CAPTURE),
    .dividend(off_x[COORD_W-1:0]), .divisor(csz), .quotient(qx), .done(done_x)
  );
  seq_divider #(.W(COORD_W)) u_div_y (
    .clk(clk), .rst(rst), .start(state == CAPTURE),
    .dividend(off_y[COORD_W-1:0]), .divisor(csz), .quotient(qy), .done(done_y)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kind <= NONE;
      hist_l <= '0;
      hist_r <= '0;
      arm <= '0;
      mx <= '0;
      my <= '0;
      bx <= '0;
      by <= '0;
      bsz <= '0;
      csz <= '0;
      bnum <= '0;
      evt_valid <= 1'b0;
      evt_type <= NONE;
      cell_x <= '0;
      cell_y <= '0;
      busy <= 1'b0;
      evt_drop <= 1'b0;
    end else begin
      hist_l <= {hist_l[0], left};
      hist_r <= {hist_r[0], right};
      arm <= {arm[0], 1'b1};
      evt_drop <= any_rise && state != IDLE;
      case (state)
        IDLE: if (any_rise) begin
          state <= CAPTURE;
          busy <= 1'b1;
          kind <= click_kind(rise_l, rise_r);
          mx <= mouse_xpos;
          my <= mouse_ypos;
          bx <= board_xpos;
          by <= board_ypos;
          bsz <= board_size;
          csz <= button_size;
          bnum <= button_num;
        end
        CAPTURE: state <= DIVIDE;
        DIVIDE: if (done_x && done_y) state <= CHECK;
        CHECK: begin
          state <= in_range ? HOLD : IDLE;
          busy <= in_range;
          evt_valid <= in_range;
          if (in_range) begin
            evt_type <= kind;
            cell_x <= qx[IDX_W-1:0] + IDX_W'(1);
            cell_y <= qy[IDX_W-1:0] + IDX_W'(1);
          end
        end
        HOLD: if (evt_ready) begin
          state <= IDLE;
          busy <= 1'b0;
          evt_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_click_decoder.sv
// tb_click_decoder: directed and randomized checks of click_decoder against an arithmetic reference.
module tb_click_decoder;
  localparam int CW = 12;
  localparam int IW = 5;
  localparam int LAT = CW + 3;
`ifdef CLICK_DECODER_CHORD_EN
  localparam bit CHORD_EN = 1'b1;
`else
  localparam bit CHORD_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [CW-1:0] mouse_xpos, mouse_ypos, board_xpos, board_ypos, board_size, button_size;
  logic [IW-1:0] button_num, cell_x, cell_y;
  logic left, right, evt_ready, evt_valid, busy, evt_drop;
  logic [1:0] evt_type;
  int errors = 0, checks = 0;
  int v_first, v_count, drops;
  logic busy14, busy15;
  logic [1:0] g_type;
  logic [IW-1:0] g_x, g_y;

  click_decoder #(.COORD_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .left(left), .right(right), .board_xpos(board_xpos), .board_ypos(board_ypos),
    .board_size(board_size), .button_size(button_size), .button_num(button_num),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .cell_x(cell_x), .cell_y(cell_y), .busy(busy), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: cell = offset / cell size + 1, valid only inside the board and within button_num.
  function automatic void ref_click(input int mx, input int my, output bit ok, output int cx, output int cy);
    int ox, oy, bs, cs, bn;
    ox = mx - int'(board_xpos);
    oy = my - int'(board_ypos);
    bs = int'(board_size);
    cs = int'(button_size);
    bn = int'(button_num);
    ok = ox >= 0 && oy >= 0 && ox < bs && oy < bs && cs != 0 && bn != 0;
    cx = 0;
    cy = 0;
    if (ok) begin
      cx = ox / cs + 1;
      cy = oy / cs + 1;
      ok = cx <= bn && cy <= bn;
    end
  endfunction

  function automatic int ref_type(input bit l, input bit r);
    if (l && r) return CHORD_EN ? 3 : 1;
    return l ? 1 : 2;
  endfunction

  // Presses the buttons for `hold` sampled edges and records len cycles of outputs.
  // Index n is the negedge after the n-th posedge counting the sampling edge as 0.
  task automatic do_click(input int x, input int y, input bit l, input bit r, input int hold, input int len);
    @(negedge clk);
    mouse_xpos = CW'(x);
    mouse_ypos = CW'(y);
    left = l;
    right = r;
    v_first = -1;
    v_count = 0;
    drops = 0;
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (v_first < 0) begin
          v_first = n;
          g_type = evt_type;
          g_x = cell_x;
          g_y = cell_y;
        end
        v_count++;
      end
      if (evt_drop) drops++;
      if (n == LAT - 1) busy14 = busy;
      if (n == LAT) busy15 = busy;
      if (n == 3) begin
        mouse_xpos = CW'($urandom_range(0, 4095));
        mouse_ypos = CW'($urandom_range(0, 4095));
      end
      if (n == hold - 1) begin
        left = 1'b0;
        right = 1'b0;
      end
    end
  endtask

  initial begin
    int x, y, sel, cnt, ex, ey;
    bit ok, l, r;
    board_xpos = 100;
    board_ypos = 50;
    board_size = 320;
    button_size = 40;
    button_num = 8;
    mouse_xpos = 0;
    mouse_ypos = 0;
    left = 0;
    right = 0;
    evt_ready = 1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {evt_valid, busy, evt_drop, evt_type, cell_x, cell_y}, 0);
    rst = 1;
    repeat (4) @(negedge clk);
    // Basic reveal with exact latency and one-cycle handshake.
    do_click(185, 130, 1, 0, 3, 30);
    check("reveal_latency", v_first, LAT);
    check("reveal_count", v_count, 1);
    check("reveal_type", g_type, 1);
    check("reveal_cell", {g_x, g_y}, {5'd3, 5'd3});
    check("reveal_nodrop", drops, 0);
    // Held right button gives one flag at the far corner.
    do_click(419, 369, 0, 1, 100, 110);
    check("flag_count", v_count, 1);
    check("flag_latency", v_first, LAT);
    check("flag_type", g_type, 2);
    check("flag_cell", {g_x, g_y}, {5'd8, 5'd8});
    do_click(420, 60, 1, 0, 3, 30);
    check("right_edge_out", v_count, 0);
    check("right_edge_nodrop", drops, 0);
    check("right_edge_idle", busy15, 0);
    do_click(99, 60, 1, 0, 3, 30);
    check("left_edge_out", v_count, 0);
    check("left_edge_nodrop", drops, 0);
    // Pending event survives a second click, which is dropped.
    evt_ready = 0;
    do_click(185, 130, 1, 0, 3, 40);
    check("hold_latency", v_first, LAT);
    check("hold_count", v_count, 40 - LAT);
    do_click(300, 300, 1, 0, 3, 6);
    check("hold_drop", drops, 1);
    check("hold_still_valid", v_count, 6);
    check("hold_stable", {g_type, g_x, g_y}, {2'd1, 5'd3, 5'd3});
    check("hold_busy", busy, 1);
    @(negedge clk);
    evt_ready = 1;
    @(negedge clk);
    check("hold_release", {evt_valid, busy}, 0);
    // Simultaneous edges.
    do_click(140, 50, 1, 1, 3, 30);
    check("chord_count", v_count, 1);
    check("chord_type", g_type, ref_type(1, 1));
    check("chord_cell", {g_x, g_y}, {5'd2, 5'd1});
    // Reset in the middle of the divide.
    @(negedge clk);
    mouse_xpos = 185;
    mouse_ypos = 130;
    left = 1;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 0;
    left = 0;
    #1;
    check("mid_reset_outputs", {evt_valid, busy, evt_drop, evt_type, cell_x, cell_y}, 0);
    repeat (5) @(negedge clk);
    check("reset_held_outputs", {evt_valid, busy, evt_drop, evt_type, cell_x, cell_y}, 0);
    rst = 1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (evt_valid || busy) cnt++;
    end
    check("reset_abort", cnt, 0);
    do_click(185, 130, 1, 0, 3, 30);
    check("post_reset_click", {v_first[7:0], g_type, g_x, g_y}, {8'(LAT), 2'd1, 5'd3, 5'd3});
    // Button held while reset releases.
    @(negedge clk);
    rst = 0;
    left = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid || busy) cnt++;
    end
    check("held_through_reset", cnt, 0);
    left = 0;
    repeat (3) @(negedge clk);
    // Degenerate geometry.
    button_size = 0;
    do_click(185, 130, 1, 0, 3, 30);
    check("size0_noevt", v_count, 0);
    check("size0_busy_late", busy14, 1);
    check("size0_idle", busy15, 0);
    check("size0_nodrop", drops, 0);
    button_size = 40;
    button_num = 0;
    do_click(185, 130, 1, 0, 3, 30);
    check("num0_noevt", v_count, 0);
    check("num0_idle", busy15, 0);
    button_num = 8;
    // Randomized clicks against the reference.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        button_size = CW'($urandom_range(0, 60));
        button_num = IW'($urandom_range(0, 12));
      end else begin
        button_size = 40;
        button_num = 8;
      end
      x = 80 + $urandom_range(0, 360);
      y = 30 + $urandom_range(0, 360);
      sel = $urandom_range(1, 3);
      l = sel[0];
      r = sel[1];
      ref_click(x, y, ok, ex, ey);
      do_click(x, y, l, r, $urandom_range(1, 5), 30);
      check("rnd_nodrop", drops, 0);
      if (ok) begin
        check("rnd_latency", v_first, LAT);
        check("rnd_count", v_count, 1);
        check("rnd_type", g_type, ref_type(l, r));
        check("rnd_cell", {g_x, g_y}, {5'(ex), 5'(ey)});
      end else begin
        check("rnd_noevt", v_count, 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
